// File: rtl/scan_seq.sv
// Programmable 3-bit index sequencer feeding a 3-to-8 decoder select.
// Dwells DWELL cycles per index; supports up, down, single-sweep and bounce patterns.
module scan_seq #(
    parameter int unsigned DWELL = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic [1:0] mode,
    input  logic [2:0] load_idx,
    output logic [2:0] sel,
    output logic       active,
    output logic       wrap,
    output logic       done
);

    localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    localparam logic [1:0] MODE_UP     = 2'b00;
    localparam logic [1:0] MODE_DOWN   = 2'b01;
    localparam logic [1:0] MODE_SWEEP  = 2'b10;
    localparam logic [1:0] MODE_BOUNCE = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    sel_q, sel_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    mode_q, mode_d;
    logic          dir_q, dir_d;
    logic          wrap_q, wrap_d;
    logic          done_q, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 3'd0;
            cnt_q   <= '0;
            mode_q  <= 2'b00;
            dir_q   <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        dir_d   = dir_q;
        wrap_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    sel_d   = load_idx;
                    mode_d  = mode;
                    cnt_d   = '0;
                    dir_d   = (mode == MODE_DOWN);
                end
            end
            RUN: begin
                // stop has priority over a coincident step so sel freezes in place
                if (stop) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    case (mode_q)
                        MODE_UP: begin
                            sel_d  = sel_q + 3'd1;
                            wrap_d = (sel_q == 3'd7);
                        end
                        MODE_DOWN: begin
                            sel_d  = sel_q - 3'd1;
                            wrap_d = (sel_q == 3'd0);
                        end
                        MODE_SWEEP: begin
                            if (sel_q == 3'd7) begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end else begin
                                sel_d = sel_q + 3'd1;
                            end
                        end
                        MODE_BOUNCE: begin
                            if (!dir_q && sel_q == 3'd7) begin
                                dir_d  = 1'b1;
                                sel_d  = 3'd6;
                                wrap_d = 1'b1;
                            end else if (dir_q && sel_q == 3'd0) begin
                                dir_d  = 1'b0;
                                sel_d  = 3'd1;
                                wrap_d = 1'b1;
                            end else if (dir_q) begin
                                sel_d = sel_q - 3'd1;
                            end else begin
                                sel_d = sel_q + 3'd1;
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sel    = sel_q;
    assign active = (state_q == RUN);
    assign wrap   = wrap_q;
    assign done   = done_q;

endmodule

// File: tb/tb_scan_seq.sv
// Directed test of scan_seq; three instances cover DWELL = 4, 1 and 2 on shared stimulus.
module tb_scan_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [2:0] load_idx = 3'd0;

    logic [2:0] sel_a, sel_b, sel_c;
    logic       active_a, active_b, active_c;
    logic       wrap_a, wrap_b, wrap_c;
    logic       done_a, done_b, done_c;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    scan_seq #(.DWELL(4)) dut_a (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .load_idx(load_idx),
        .sel(sel_a), .active(active_a), .wrap(wrap_a), .done(done_a)
    );
    scan_seq #(.DWELL(1)) dut_b (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .load_idx(load_idx),
        .sel(sel_b), .active(active_b), .wrap(wrap_b), .done(done_b)
    );
    scan_seq #(.DWELL(2)) dut_c (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .load_idx(load_idx),
        .sel(sel_c), .active(active_c), .wrap(wrap_c), .done(done_c)
    );

    // Advance one edge and settle before sampling outputs
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic launch(input logic [1:0] m, input logic [2:0] l);
        start = 1'b1; mode = m; load_idx = l;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; mode = 2'b00; load_idx = 3'd5;
        tick();
        tick();
        compared++;
        if (sel_a !== 3'd0 || active_a !== 1'b0 || wrap_a !== 1'b0 || done_a !== 1'b0) begin
            mismatched++;
            $display("FAIL reset: sel=%0d active=%b wrap=%b done=%b, required sel=0 active=0 wrap=0 done=0",
                     sel_a, active_a, wrap_a, done_a);
        end
        rst = 1'b0; start = 1'b0;
        tick();
        compared++;
        if (active_b !== 1'b0 || sel_b !== 3'd0) begin
            mismatched++;
            $display("FAIL reset_release: active=%b sel=%0d, required active=0 sel=0", active_b, sel_b);
        end
        $display("reset: rst held 2 cycles with start=1, outputs idle");
    endtask

    task automatic test_up();
        logic [2:0] e;
        do_reset();
        launch(2'b00, 3'd5);
        for (int i = 0; i < 20; i++) begin
            e = 3'((5 + i / 4) % 8);
            compared++;
            if (sel_a !== e || active_a !== 1'b1 || wrap_a !== (i == 12)) begin
                mismatched++;
                $display("FAIL up[%0d]: sel=%0d active=%b wrap=%b, required sel=%0d active=1 wrap=%b",
                         i, sel_a, active_a, wrap_a, e, (i == 12));
            end
            tick();
        end
        // the preceding tick landed on a step edge; stop was not yet asserted, so re-check at a fresh step
        // edge k+20 already stepped to 2; now run to k+24 with stop on that edge
        tick(); tick(); tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        compared++;
        if (sel_a !== 3'd2 || active_a !== 1'b0 || wrap_a !== 1'b0) begin
            mismatched++;
            $display("FAIL stop_on_step: sel=%0d active=%b wrap=%b, required sel=2 active=0 wrap=0",
                     sel_a, active_a, wrap_a);
        end
        $display("up: DWELL=4 load=5 swept 5,6,7,0,1 then stop on step edge");
    endtask

    task automatic test_down();
        logic [2:0] es [4] = '{3'd1, 3'd0, 3'd7, 3'd6};
        logic       ew [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        launch(2'b01, 3'd1);
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (sel_b !== es[i] || wrap_b !== ew[i] || active_b !== 1'b1) begin
                mismatched++;
                $display("FAIL down[%0d]: sel=%0d wrap=%b active=%b, required sel=%0d wrap=%b active=1",
                         i, sel_b, wrap_b, active_b, es[i], ew[i]);
            end
            tick();
        end
        $display("down: DWELL=1 load=1 swept 1,0,7,6");
    endtask

    task automatic test_sweep();
        logic [2:0] es [6] = '{3'd5, 3'd5, 3'd6, 3'd6, 3'd7, 3'd7};
        do_reset();
        launch(2'b10, 3'd5);
        for (int i = 0; i < 6; i++) begin
            compared++;
            if (sel_c !== es[i] || active_c !== 1'b1 || done_c !== 1'b0) begin
                mismatched++;
                $display("FAIL sweep[%0d]: sel=%0d active=%b done=%b, required sel=%0d active=1 done=0",
                         i, sel_c, active_c, done_c, es[i]);
            end
            if (i < 5) tick();
        end
        tick();
        compared++;
        if (done_c !== 1'b1 || active_c !== 1'b0 || sel_c !== 3'd7) begin
            mismatched++;
            $display("FAIL sweep_done: done=%b active=%b sel=%0d, required done=1 active=0 sel=7",
                     done_c, active_c, sel_c);
        end
        $display("sweep: DWELL=2 load=5 done at edge k+6");
    endtask

    task automatic test_back_to_back();
        // dut_c is idle with done high; restart on the very next edge
        launch(2'b10, 3'd2);
        compared++;
        if (done_c !== 1'b0 || active_c !== 1'b1 || sel_c !== 3'd2) begin
            mismatched++;
            $display("FAIL restart: done=%b active=%b sel=%0d, required done=0 active=1 sel=2",
                     done_c, active_c, sel_c);
        end
        tick();
        compared++;
        if (sel_c !== 3'd2) begin
            mismatched++;
            $display("FAIL restart_dwell: sel=%0d, required sel=2", sel_c);
        end
        tick();
        compared++;
        if (sel_c !== 3'd3) begin
            mismatched++;
            $display("FAIL restart_step: sel=%0d, required sel=3", sel_c);
        end
        $display("back_to_back: restart from load=2 right after done");
    endtask

    task automatic test_bounce();
        logic [2:0] es [10] = '{3'd6, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1};
        do_reset();
        launch(2'b11, 3'd6);
        for (int i = 0; i < 10; i++) begin
            compared++;
            if (sel_b !== es[i] || wrap_b !== (i == 2 || i == 9)) begin
                mismatched++;
                $display("FAIL bounce[%0d]: sel=%0d wrap=%b, required sel=%0d wrap=%b",
                         i, sel_b, wrap_b, es[i], (i == 2 || i == 9));
            end
            tick();
        end
        $display("bounce: DWELL=1 load=6 reversed at 7 and 0");
    endtask

    task automatic test_controls();
        do_reset();
        start = 1'b1; stop = 1'b1; mode = 2'b00; load_idx = 3'd3;
        tick();
        start = 1'b0; stop = 1'b0;
        compared++;
        if (active_b !== 1'b1 || sel_b !== 3'd3) begin
            mismatched++;
            $display("FAIL start_with_stop: active=%b sel=%0d, required active=1 sel=3", active_b, sel_b);
        end
        tick();
        compared++;
        if (sel_b !== 3'd4) begin
            mismatched++;
            $display("FAIL step_after_start: sel=%0d, required sel=4", sel_b);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        compared++;
        if (active_b !== 1'b0 || sel_b !== 3'd4) begin
            mismatched++;
            $display("FAIL stop_dwell1: active=%b sel=%0d, required active=0 sel=4", active_b, sel_b);
        end
        tick();
        compared++;
        if (active_b !== 1'b0 || sel_b !== 3'd4) begin
            mismatched++;
            $display("FAIL idle_hold: active=%b sel=%0d, required active=0 sel=4", active_b, sel_b);
        end
        $display("controls: start+stop starts, stop freezes sel");
    endtask

    task automatic test_reset_mid_sweep();
        do_reset();
        launch(2'b10, 3'd7);
        tick();
        compared++;
        if (sel_c !== 3'd7 || active_c !== 1'b1) begin
            mismatched++;
            $display("FAIL pre_rst: sel=%0d active=%b, required sel=7 active=1", sel_c, active_c);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        compared++;
        if (done_c !== 1'b0 || sel_c !== 3'd0 || active_c !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_mid_sweep: done=%b sel=%0d active=%b, required done=0 sel=0 active=0",
                     done_c, sel_c, active_c);
        end
        tick();
        compared++;
        if (done_c !== 1'b0 || active_c !== 1'b0) begin
            mismatched++;
            $display("FAIL post_rst: done=%b active=%b, required done=0 active=0", done_c, active_c);
        end
        $display("reset_mid_sweep: rst at sel=7 suppresses done");
    endtask

    initial begin
        #1;
        test_reset();
        test_up();
        test_down();
        test_sweep();
        test_back_to_back();
        test_bounce();
        test_controls();
        test_reset_mid_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
